// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with round-robin or fixed-priority arbitration,
// optional packet lock across multi-beat packets, and a single registered output stage.
module rr_stream_mux #(
  parameter int N       = 4,
  parameter int WIDTH   = 32,
  parameter int PKTLOCK = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fix_pri,
  input  logic [N*WIDTH-1:0]     in_data,
  input  logic [N-1:0]           in_valid,
  input  logic [N-1:0]           in_last,
  output logic [N-1:0]           in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [$clog2(N)-1:0]   out_sel,
  input  logic                   out_ready,
  output logic                   lock_active
);

  localparam int SW = $clog2(N);

  typedef enum logic {
    ARBITRATE = 1'b0,
    HOLD      = 1'b1
  } lock_state_e;

  lock_state_e      lock_state;
  logic [SW-1:0]    lock_ch;
  logic [SW-1:0]    ptr;
  logic [SW-1:0]    grant;
  logic [SW-1:0]    next_ptr;
  logic [SW:0]      scan;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic             found;
  logic             load;
  logic             xfer;

  assign load = ~out_valid | out_ready;

  // Candidate selection: the locked channel while a packet is open, otherwise the lowest valid
  // index (fixed priority) or the first valid index scanning upward from ptr with wrap-around.
  always_comb begin
    grant = '0;
    found = 1'b0;
    scan  = '0;
    if (lock_state == HOLD) begin
      grant = lock_ch;
      found = in_valid[lock_ch];
    end else if (fix_pri) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant = SW'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        scan = {1'b0, ptr} + (SW + 1)'(k);
        if (scan >= (SW + 1)'(N)) begin
          scan = scan - (SW + 1)'(N);
        end
        if (in_valid[scan[SW-1:0]]) begin
          grant = scan[SW-1:0];
          found = 1'b1;
        end
      end
    end
  end

  assign xfer     = reset_n & load & found;
  assign sel_data = in_data[grant*WIDTH +: WIDTH];
  assign sel_last = in_last[grant];
  assign next_ptr = (grant == SW'(N - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign lock_active = (lock_state == HOLD);

  // A transfer always overwrites the output register, so a drain and fill in the same cycle
  // produces no bubble; without a transfer the register empties but keeps its data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_sel    <= '0;
      ptr        <= '0;
      lock_state <= ARBITRATE;
      lock_ch    <= '0;
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_sel   <= grant;
        if ((PKTLOCK != 0) && !sel_last) begin
          lock_state <= HOLD;
          lock_ch    <= grant;
        end else begin
          lock_state <= ARBITRATE;
        end
        if ((PKTLOCK == 0) || sel_last) begin
          ptr <= next_ptr;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Randomised and directed bench for rr_stream_mux: a packet-locking and a non-locking instance
// share stimulus and are each compared against a behavioural arbitration model.
module tb_rr_stream_mux;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic           clk       = 1'b0;
  logic           reset_n   = 1'b0;
  logic           fix_pri   = 1'b0;
  logic           out_ready = 1'b0;
  logic [N*W-1:0] in_data   = '0;
  logic [N-1:0]   in_valid  = '0;
  logic [N-1:0]   in_last   = '0;

  logic [N-1:0]   rdy [2];
  logic [W-1:0]   od  [2];
  logic           ov  [2];
  logic           ol  [2];
  logic           la  [2];
  logic [SW-1:0]  os  [2];

  int vectors     = 0;
  int miscompares = 0;

  string pfx [2] = '{"lock_", "nolock_"};

  int         m_ptr    [2];
  int         m_lockch [2];
  int         m_os     [2];
  int         g_idx    [2];
  bit         m_lock   [2];
  bit         m_ov     [2];
  bit         m_ol     [2];
  bit         g_found  [2];
  bit         g_load   [2];
  logic [W-1:0] m_od   [2];

  always #5 clk = ~clk;

  rr_stream_mux #(.N(N), .WIDTH(W), .PKTLOCK(1)) dut_lock (
    .clk(clk), .reset_n(reset_n), .fix_pri(fix_pri), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy[0]), .out_data(od[0]), .out_valid(ov[0]), .out_last(ol[0]),
    .out_sel(os[0]), .out_ready(out_ready), .lock_active(la[0])
  );

  rr_stream_mux #(.N(N), .WIDTH(W), .PKTLOCK(0)) dut_nolock (
    .clk(clk), .reset_n(reset_n), .fix_pri(fix_pri), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy[1]), .out_data(od[1]), .out_valid(ov[1]), .out_last(ol[1]),
    .out_sel(os[1]), .out_ready(out_ready), .lock_active(la[1])
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic bit pktlock(input int m);
    return (m == 0);
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0; m_lockch[m] = 0; m_os[m] = 0;
      m_lock[m] = 0; m_ov[m] = 0; m_ol[m] = 0; m_od[m] = '0;
    end
  endtask

  // Arbitration rules stated directly: open packet keeps its channel; otherwise scan from
  // index 0 (fixed priority) or from the pointer modulo N (round-robin).
  task automatic modelGrant(input int m);
    g_found[m] = 0;
    g_idx[m]   = 0;
    g_load[m]  = !m_ov[m] || out_ready;
    if (m_lock[m]) begin
      g_idx[m]   = m_lockch[m];
      g_found[m] = in_valid[m_lockch[m]];
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = fix_pri ? k : (m_ptr[m] + k) % N;
        if (!g_found[m] && in_valid[c]) begin
          g_found[m] = 1;
          g_idx[m]   = c;
        end
      end
    end
  endtask

  function automatic logic [N-1:0] expReady(input int m);
    logic [N-1:0] e;
    e = '0;
    if (g_load[m] && g_found[m]) e[g_idx[m]] = 1'b1;
    return e;
  endfunction

  task automatic modelStep(input int m);
    if (g_load[m]) begin
      if (g_found[m]) begin
        int g;
        g = g_idx[m];
        m_od[m] = in_data[g*W +: W];
        m_ol[m] = in_last[g];
        m_os[m] = g;
        m_ov[m] = 1;
        if (pktlock(m)) begin
          m_lock[m]   = !in_last[g];
          m_lockch[m] = g;
        end
        if (!pktlock(m) || in_last[g]) m_ptr[m] = (g + 1) % N;
      end else begin
        m_ov[m] = 0;
      end
    end
  endtask

  task automatic checkInst(input int m);
    checkOutput({pfx[m], "valid"}, 64'(ov[m]), 64'(m_ov[m]));
    checkOutput({pfx[m], "data"},  64'(od[m]), 64'(m_od[m]));
    checkOutput({pfx[m], "last"},  64'(ol[m]), 64'(m_ol[m]));
    checkOutput({pfx[m], "sel"},   64'(os[m]), 64'(m_os[m]));
    checkOutput({pfx[m], "lock"},  64'(la[m]), 64'(m_lock[m]));
  endtask

  // Called at a falling edge; checks ready before the rising edge and registers just after it.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l,
                               input logic [N*W-1:0] d, input logic ordy, input logic fp);
    in_valid  = v;
    in_last   = l;
    in_data   = d;
    out_ready = ordy;
    fix_pri   = fp;
    #1;
    for (int m = 0; m < 2; m++) begin
      modelGrant(m);
      checkOutput({pfx[m], "ready"}, 64'(rdy[m]), 64'(expReady(m)));
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) modelStep(m);
    #1;
    for (int m = 0; m < 2; m++) checkInst(m);
    @(negedge clk);
  endtask

  function automatic logic [N*W-1:0] rndData();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  function automatic logic [N*W-1:0] withCh1(input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = rndData();
    r[W +: W] = v;
    return r;
  endfunction

  initial begin
    modelReset();
    in_valid = 4'b1111;
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      checkOutput({pfx[m], "rst_valid"}, 64'(ov[m]), 64'(0));
      checkOutput({pfx[m], "rst_ready"}, 64'(rdy[m]), 64'(0));
      checkOutput({pfx[m], "rst_lock"},  64'(la[m]), 64'(0));
    end
    reset_n = 1'b1;

    repeat (3) applyStimulus(4'b0000, 4'b0000, rndData(), 1'b1, 1'b0);
    checkOutput("idle_valid", 64'(ov[0]), 64'(0));
    checkOutput("idle_ready", 64'(rdy[0]), 64'(0));

    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b1111, 4'b1111, rndData(), 1'b1, 1'b0);
      checkOutput("rr_sel", 64'(os[1]), 64'(i % 4));
      checkOutput("rr_valid", 64'(ov[1]), 64'(1));
    end

    repeat (3) begin
      applyStimulus(4'b0110, 4'b1111, rndData(), 1'b1, 1'b1);
      checkOutput("fp_sel", 64'(os[0]), 64'(1));
    end
    applyStimulus(4'b0100, 4'b1111, rndData(), 1'b1, 1'b1);
    checkOutput("fp_drop_sel", 64'(os[0]), 64'(2));

    applyStimulus(4'b0100, 4'b0000, rndData(), 1'b1, 1'b0);
    checkOutput("pkt_b1_sel", 64'(os[0]), 64'(2));
    checkOutput("pkt_b1_lock", 64'(la[0]), 64'(1));
    applyStimulus(4'b0101, 4'b0000, rndData(), 1'b1, 1'b1);
    checkOutput("pkt_b2_sel", 64'(os[0]), 64'(2));
    checkOutput("pkt_b2_lock", 64'(la[0]), 64'(1));
    applyStimulus(4'b0001, 4'b0000, rndData(), 1'b1, 1'b0);
    checkOutput("pkt_gap_valid", 64'(ov[0]), 64'(0));
    checkOutput("pkt_gap_ready", 64'(rdy[0]), 64'(0));
    applyStimulus(4'b0101, 4'b0100, rndData(), 1'b1, 1'b0);
    checkOutput("pkt_b3_sel", 64'(os[0]), 64'(2));
    checkOutput("pkt_b3_last", 64'(ol[0]), 64'(1));
    checkOutput("pkt_b3_lock", 64'(la[0]), 64'(0));
    applyStimulus(4'b0101, 4'b0101, rndData(), 1'b1, 1'b0);
    checkOutput("pkt_after_sel", 64'(os[0]), 64'(0));

    applyStimulus(4'b0010, 4'b0010, withCh1(32'hA5A5_0001), 1'b1, 1'b0);
    checkOutput("bp_first_data", 64'(od[0]), 64'(32'hA5A5_0001));
    repeat (3) begin
      applyStimulus(4'b0010, 4'b0010, withCh1(32'hA5A5_0002), 1'b0, 1'b0);
      checkOutput("bp_hold_data", 64'(od[0]), 64'(32'hA5A5_0001));
      checkOutput("bp_hold_ready", 64'(rdy[0]), 64'(0));
    end
    applyStimulus(4'b0010, 4'b0010, withCh1(32'hA5A5_0002), 1'b1, 1'b0);
    checkOutput("bp_release_data", 64'(od[0]), 64'(32'hA5A5_0002));
    checkOutput("bp_release_valid", 64'(ov[0]), 64'(1));

    applyStimulus(4'b1000, 4'b0000, rndData(), 1'b1, 1'b0);
    checkOutput("mid_pkt_sel", 64'(os[0]), 64'(3));
    checkOutput("mid_pkt_lock", 64'(la[0]), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checkOutput({pfx[m], "async_valid"}, 64'(ov[m]), 64'(0));
      checkOutput({pfx[m], "async_data"},  64'(od[m]), 64'(0));
      checkOutput({pfx[m], "async_sel"},   64'(os[m]), 64'(0));
      checkOutput({pfx[m], "async_last"},  64'(ol[m]), 64'(0));
      checkOutput({pfx[m], "async_lock"},  64'(la[m]), 64'(0));
      checkOutput({pfx[m], "async_ready"}, 64'(rdy[m]), 64'(0));
    end
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(4'b1111, 4'b1111, rndData(), 1'b1, 1'b0);
    checkOutput("post_rst_sel_lock", 64'(os[0]), 64'(0));
    checkOutput("post_rst_sel_nolock", 64'(os[1]), 64'(0));

    for (int i = 0; i < 500; i++) begin
      applyStimulus(4'($urandom), 4'($urandom), rndData(),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- N-channel streaming multiplexer. Replaces the fixed-select combinational muxN family wherever several producers share one consumer.
- Arbitrates among valid/ready input channels, either round-robin or fixed-priority.
- With PKTLOCK=1, holds the grant for the whole multi-beat packet, delimited by last.
- Registers the selected beat into a single output stage, which supports full throughput under backpressure.

Parameters:
- N, 4: number of input channels; legal range 2..64.
- WIDTH, 32: data width per channel.
- PKTLOCK, 1: 1 holds the grant until a last beat transfers; 0 re-arbitrates on every beat.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- fix_pri  input  1  1 selects fixed priority (lowest index wins); 0 selects round-robin.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_last  input  N  per-channel end-of-packet flag.
- in_ready  output  N  per-channel ready; at most one bit high.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_last  output  1  registered last.
- out_sel  output  $clog2(N)  channel index of the beat currently in the output register.
- out_ready  input  1  consumer ready.
- lock_active  output  1  high while a packet is mid-transfer and the grant is held.

Behaviour:
- Reset: asynchronous assert when reset_n=0. Every output and state bit clears immediately: out_valid=0, out_data=0, out_last=0, out_sel=0, rr pointer ptr=0, lock=0, locked channel=0. in_ready=0 while in reset.
- Reset mid-packet: the partial packet is discarded and the lock is cleared. There is no recovery beat.
- load = ~out_valid | out_ready. The output register accepts a new beat when it is empty or being drained in the same cycle.
- Grant selection, combinational, evaluated only when load=1:
  - lock=1: the candidate is the locked channel only.
  - lock=0, fix_pri=1: the candidate is the lowest-index valid channel.
  - lock=0, fix_pri=0: the candidate is the first valid channel scanning ptr, ptr+1, …, N-1, 0, …, ptr-1, with wrap-around.
- in_ready[g]=1 only for the granted channel g, and only if load=1 and in_valid[g]=1. All other bits are 0.
- This path is combinational valid→ready. Producers must not gate valid on ready.
- Transfer on in_valid[g] & in_ready[g]: at the next edge out_data=in_data[g], out_last=in_last[g], out_sel=g, out_valid=1.
- If load=1 and there is no transfer: out_valid<=0 (drained or stays empty) and the data registers hold their values.
- If load=0: all output registers hold. out_data and out_last must remain stable while out_valid & ~out_ready.
- Latency: input beat to out_valid is 1 cycle. Sustained throughput is 1 beat/cycle with out_ready held high.
- Lock (PKTLOCK=1):
  - A transfer with in_last[g]=0 sets lock=1 and locked channel=g.
  - A transfer with in_last[g]=1 clears lock.
  - A single-beat packet (last on first beat) never sets lock.
  - lock_active = lock.
- PKTLOCK=0: lock is tied to 0 and lock_active=0. in_last only propagates to out_last.
- Round-robin pointer: updates to (g+1) mod N only on a transfer that ends arbitration, i.e. in_last[g]=1 or PKTLOCK=0. ptr is unaffected in fixed-priority mode except by that same update rule.
- fix_pri changing mid-packet has no effect until the lock releases.
- A locked channel deasserting valid stalls the output (bubbles inserted). Other channels are not granted.
- Simultaneous drain and fill in the same cycle: the output register is overwritten with no bubble.

Test Plan:
- Reset then idle: reset_n=0 asserted asynchronously mid-cycle -> all outputs 0 immediately. Release with no valid -> out_valid stays 0 and in_ready=0000.
- RR fairness: N=4, PKTLOCK=0, fix_pri=0, in_valid=1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles with out_valid continuously 1.
- Fixed priority: fix_pri=1, in_valid=0110 -> only channel 1 is granted repeatedly. Drop in_valid[1] -> channel 2 is granted the next cycle.
- Packet lock: PKTLOCK=1, ch2 sends 3 beats (last on the 3rd) while ch0 is valid throughout -> out_sel=2,2,2 then 0. lock_active is high from after beat 1 until after beat 3. A gap in ch2 valid produces bubbles, not ch0 beats.
- Backpressure: out_ready=0 for 3 cycles with ch1 valid, data 0xA5A5_0001 -> out_data holds 0xA5A5_0001 and in_ready=0000 during the stall. On release, the next beat follows with no bubble.
- Reset mid-packet: assert reset_n=0 during a locked ch3 packet -> lock_active=0 and ptr=0. After release, ch0 is granted first when all channels are valid.
